ui_io_master: RTL

Bus-side initiator for the UI controller: accepts load/store requests from the processor memory stage over a valid/ready handshake and decodes memory-mapped UI addresses. It sequences the controller's device-select/write-enable/data port and returns read data. Between requests it polls KEY and SW, keeps sticky change status with overrun, and raises an interrupt. It sits between the memory stage and the UI controller, which latches writes on the falling edge within the access cycle.

---
 rtl/ui_io_master.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ui_io_master.sv
// Bus initiator for the UI controller: decodes load/store requests, drives the UI port, polls KEY/SW.
// Latency: response 2 cycles after handshake; req_ready low during ACC/RSP; responses cannot be stalled.
module ui_io_master #(
  parameter int               DBITS      = 32,
  parameter logic [DBITS-1:0] HEX_ADDR   = 32'hF000_0000,
  parameter logic [DBITS-1:0] LEDR_ADDR  = 32'hF000_0004,
  parameter logic [DBITS-1:0] KEY_ADDR   = 32'hF000_0010,
  parameter logic [DBITS-1:0] KCTRL_ADDR = 32'hF000_0110,
  parameter logic [DBITS-1:0] SW_ADDR    = 32'hF000_0014,
  parameter logic [DBITS-1:0] SCTRL_ADDR = 32'hF000_0114
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [DBITS-1:0] req_addr,
  input  logic [DBITS-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [DBITS-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [1:0]       ui_device,
  output logic             ui_wrtEn,
  output logic [DBITS-1:0] ui_in,
  input  logic [DBITS-1:0] ui_out,
  output logic             irq
);

  localparam logic [1:0] UI_KEY  = 2'd0;
  localparam logic [1:0] UI_SW   = 2'd1;
  localparam logic [1:0] UI_LEDR = 2'd2;
  localparam logic [1:0] UI_HEX  = 2'd3;

  typedef enum logic [1:0] {POLL, ACC, RSP} state_t;

  state_t           state;
  logic             poll_sel;  // 0: KEY is sampled this POLL cycle, 1: SW
  logic             a_we;
  logic [DBITS-1:0] a_addr;
  logic [3:0]       kval;
  logic [9:0]       sval;
  logic             kprimed, sprimed;
  logic             kready, kovr, kie;
  logic             sready, sovr, sie;

  // Control registers and stores to read-only data registers leave the UI port parked on KEY.
  function automatic logic [1:0] acc_dev(input logic we, input logic [DBITS-1:0] a);
    if (a == HEX_ADDR)            return UI_HEX;
    else if (a == LEDR_ADDR)      return UI_LEDR;
    else if (a == SW_ADDR && !we) return UI_SW;
    else                          return UI_KEY;
  endfunction

  function automatic logic [DBITS-1:0] ctrl_word(input logic rdy, input logic ovr, input logic ie);
    logic [DBITS-1:0] w;
    w    = '0;
    w[0] = rdy;
    w[2] = ovr;
    w[4] = ie;
    return w;
  endfunction

  assign req_ready = (state == POLL);
  assign irq       = (kready & kie) | (sready & sie);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= POLL;
      poll_sel  <= 1'b0;
      a_we      <= 1'b0;
      a_addr    <= '0;
      kval      <= '0;
      sval      <= '0;
      kprimed   <= 1'b0;
      sprimed   <= 1'b0;
      kready    <= 1'b0;
      kovr      <= 1'b0;
      kie       <= 1'b0;
      sready    <= 1'b0;
      sovr      <= 1'b0;
      sie       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      ui_device <= UI_KEY;
      ui_wrtEn  <= 1'b0;
      ui_in     <= '0;
    end else begin
      case (state)
        POLL: begin
          if (!poll_sel) begin
            if (!kprimed) begin
              kval    <= ui_out[3:0];
              kprimed <= 1'b1;
            end else if (ui_out[3:0] != kval) begin
              kval   <= ui_out[3:0];
              kready <= 1'b1;
              if (kready) kovr <= 1'b1;
            end
          end else begin
            if (!sprimed) begin
              sval    <= ui_out[9:0];
              sprimed <= 1'b1;
            end else if (ui_out[9:0] != sval) begin
              sval   <= ui_out[9:0];
              sready <= 1'b1;
              if (sready) sovr <= 1'b1;
            end
          end
          poll_sel <= ~poll_sel;
          if (req_valid) begin
            state     <= ACC;
            a_we      <= req_we;
            a_addr    <= req_addr;
            ui_in     <= req_wdata;
            ui_device <= acc_dev(req_we, req_addr);
            ui_wrtEn  <= req_we && (req_addr == HEX_ADDR || req_addr == LEDR_ADDR);
          end else begin
            ui_device <= poll_sel ? UI_KEY : UI_SW;
          end
        end
        ACC: begin
          state     <= RSP;
          ui_wrtEn  <= 1'b0;
          ui_device <= poll_sel ? UI_SW : UI_KEY;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          // Sampling happens only in POLL, so a clearing store here never races a detection.
          case (a_addr)
            HEX_ADDR, LEDR_ADDR: if (!a_we) rsp_rdata <= ui_out;
            KEY_ADDR: begin
              if (a_we) rsp_err <= 1'b1;
              else begin
                rsp_rdata <= ui_out;
                kready    <= 1'b0;
              end
            end
            SW_ADDR: begin
              if (a_we) rsp_err <= 1'b1;
              else begin
                rsp_rdata <= ui_out;
                sready    <= 1'b0;
              end
            end
            KCTRL_ADDR: begin
              if (a_we) begin
                kready <= kready & ui_in[0];
                kovr   <= kovr & ui_in[2];
                kie    <= ui_in[4];
              end else rsp_rdata <= ctrl_word(kready, kovr, kie);
            end
            SCTRL_ADDR: begin
              if (a_we) begin
                sready <= sready & ui_in[0];
                sovr   <= sovr & ui_in[2];
                sie    <= ui_in[4];
              end else rsp_rdata <= ctrl_word(sready, sovr, sie);
            end
            default: rsp_err <= 1'b1;
          endcase
        end
        RSP: begin
          state     <= POLL;
          rsp_valid <= 1'b0;
          ui_device <= poll_sel ? UI_SW : UI_KEY;
        end
        default: state <= POLL;
      endcase
    end
  end

endmodule
